// File: rtl/sad_mv_select.sv
`default_nettype none
// ============================================================================
// Module   : sad_mv_select
// Purpose  : Running-minimum motion-vector selector for a full-search SAD
//            engine. Optional zero-vector bias via macro SAD_ZMV_BIAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sad_mv_select #(
    parameter int SAD_W    = 32,
    parameter int RANGE    = 8,
    parameter int MV_W     = 5,
    parameter int ZMV_BIAS = 64,
    localparam int CNT_W   = $clog2((2 * RANGE + 1) * (2 * RANGE + 1))
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sad_valid,
    input  logic [SAD_W-1:0]        sad_in,
    output logic                    sad_ready,
    output logic                    mv_valid,
    input  logic                    mv_ready,
    output logic signed [MV_W-1:0]  mv_x,
    output logic signed [MV_W-1:0]  mv_y,
    output logic [SAD_W-1:0]        min_sad,
    output logic [CNT_W-1:0]        cand_cnt,
    output logic                    busy
);

    localparam int                    c_DIM   = 2 * RANGE + 1;
    localparam int                    c_NCAND = c_DIM * c_DIM;
    localparam logic [CNT_W-1:0]      c_CNT_MAX  = CNT_W'(c_NCAND);
    localparam logic [CNT_W-1:0]      c_CNT_LAST = CNT_W'(c_NCAND - 1);
    localparam logic signed [MV_W-1:0] c_POS_R = MV_W'(RANGE);
    localparam logic signed [MV_W-1:0] c_NEG_R = MV_W'(-RANGE);
    localparam logic signed [MV_W-1:0] c_ONE   = MV_W'(1);

    if ((RANGE < 1) || (RANGE > (1 << (MV_W - 1)) - 1) || (ZMV_BIAS < 0)) begin : g_param_check
        $error("sad_mv_select: MV_W cannot hold +/-RANGE, or ZMV_BIAS is negative");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_restart;
    logic                    w_accept;

    logic [CNT_W-1:0]        r_cnt;
    logic signed [MV_W-1:0]  r_dx;
    logic signed [MV_W-1:0]  r_dy;
    logic [SAD_W-1:0]        r_min_cmp;
    logic [SAD_W-1:0]        r_min_raw;
    logic signed [MV_W-1:0]  r_best_x;
    logic signed [MV_W-1:0]  r_best_y;

    logic                    w_last;
    logic                    w_take;
    logic [SAD_W-1:0]        w_cmp;
    logic signed [MV_W-1:0]  w_win_x;
    logic signed [MV_W-1:0]  w_win_y;
    logic [SAD_W-1:0]        w_win_raw;

    assign sad_ready = (r_state == S_SCAN);
    assign mv_valid  = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign cand_cnt  = r_cnt;
    assign w_last    = (r_cnt == c_CNT_LAST);

    // Only the zero vector gets the bias, clamped at 0; min_sad stays raw.
`ifdef SAD_ZMV_BIAS_EN
    always_comb begin
        w_cmp = sad_in;
        if ((r_dx == '0) && (r_dy == '0)) begin
            w_cmp = (sad_in > SAD_W'(ZMV_BIAS)) ? (sad_in - SAD_W'(ZMV_BIAS)) : '0;
        end
    end
`else
    assign w_cmp = sad_in;
`endif

    // First candidate always loads; afterwards strictly-less keeps the earliest tie.
    assign w_take    = (r_cnt == '0) || (w_cmp < r_min_cmp);
    assign w_win_x   = w_take ? r_dx   : r_best_x;
    assign w_win_y   = w_take ? r_dy   : r_best_y;
    assign w_win_raw = w_take ? sad_in : r_min_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_SCAN;
                    w_restart    = 1'b1;
                end
            end
            S_SCAN: begin
                if (start) begin
                    w_restart = 1'b1;
                end else if (sad_valid) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (mv_ready) begin
                    if (start) begin
                        w_next_state = S_SCAN;
                        w_restart    = 1'b1;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_dx      <= '0;
            r_dy      <= '0;
            r_min_cmp <= '0;
            r_min_raw <= '0;
            r_best_x  <= '0;
            r_best_y  <= '0;
            mv_x      <= '0;
            mv_y      <= '0;
            min_sad   <= '0;
        end else if (w_restart) begin
            r_cnt     <= '0;
            r_dx      <= c_NEG_R;
            r_dy      <= c_NEG_R;
            r_min_cmp <= '0;
            r_min_raw <= '0;
            r_best_x  <= '0;
            r_best_y  <= '0;
        end else if (w_accept) begin
            if (w_take) begin
                r_min_cmp <= w_cmp;
                r_min_raw <= sad_in;
                r_best_x  <= r_dx;
                r_best_y  <= r_dy;
            end
            if (r_dx == c_POS_R) begin
                r_dx <= c_NEG_R;
                r_dy <= r_dy + c_ONE;
            end else begin
                r_dx <= r_dx + c_ONE;
            end
            if (r_cnt < c_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                mv_x    <= w_win_x;
                mv_y    <= w_win_y;
                min_sad <= w_win_raw;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sad_mv_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_mv_select
// Purpose  : Directed scoreboard bench for sad_mv_select (RANGE=8, 289 cands).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sad_mv_select;

    localparam int SAD_W = 32;
    localparam int RANGE = 8;
    localparam int MV_W  = 5;
    localparam int CNT_W = 9;
    localparam int N     = 289;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   sad_valid;
    logic [SAD_W-1:0]       sad_in;
    logic                   sad_ready;
    logic                   mv_valid;
    logic                   mv_ready;
    logic signed [MV_W-1:0] mv_x;
    logic signed [MV_W-1:0] mv_y;
    logic [SAD_W-1:0]       min_sad;
    logic [CNT_W-1:0]       cand_cnt;
    logic                   busy;

    typedef struct packed {
        logic signed [MV_W-1:0] x;
        logic signed [MV_W-1:0] y;
        logic [SAD_W-1:0]       sad;
    } exp_t;

    exp_t         sb[$];
    logic [31:0]  sads[N];
    int           checks   = 0;
    int           failures = 0;

    sad_mv_select #(
        .SAD_W(SAD_W), .RANGE(RANGE), .MV_W(MV_W), .ZMV_BIAS(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sad_valid(sad_valid),
        .sad_in(sad_in), .sad_ready(sad_ready), .mv_valid(mv_valid),
        .mv_ready(mv_ready), .mv_x(mv_x), .mv_y(mv_y), .min_sad(min_sad),
        .cand_cnt(cand_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every result handshake is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst && mv_valid && mv_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=(%0d,%0d,%0d) required=none", mv_x, mv_y, min_sad);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_mv_x", 64'(mv_x), 64'(e.x));
                check("result_mv_y", 64'(mv_y), 64'(e.y));
                check("result_min_sad", 64'(min_sad), 64'(e.sad));
                check("result_cand_cnt", 64'(cand_cnt), 64'(N));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int n);
        for (int k = 0; k < n; k++) begin
            sad_valid = 1'b1;
            sad_in    = sads[k];
            tick();
        end
        sad_valid = 1'b0;
        sad_in    = '0;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int k = 0; k < N; k++) sads[k] = v;
    endtask

    task automatic expect_mv(input int x, input int y, input logic [31:0] s);
        exp_t e;
        e.x   = MV_W'(x);
        e.y   = MV_W'(y);
        e.sad = s;
        sb.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; sad_valid = 1'b0; sad_in = '0; mv_ready = 1'b1;
        repeat (3) tick();
        check("reset_flags", {mv_valid, sad_ready, busy}, 3'b000);
        check("reset_outputs", {mv_x, mv_y, min_sad, cand_cnt}, '0);
        rst = 1'b1;
        tick();

        // IDLE ignores sad_valid
        sad_valid = 1'b1; sad_in = 32'd5;
        repeat (2) tick();
        check("idle_ignores_sad", {sad_ready, busy, cand_cnt}, '0);
        sad_valid = 1'b0;

        // Ramp: last candidate is smallest, result valid for one cycle only
        for (int k = 0; k < N; k++) sads[k] = 32'(1000 - k);
        expect_mv(8, 8, 32'd712);
        start_pulse();
        check("scan_entry", {busy, sad_ready, cand_cnt}, {2'b11, 9'd0});
        feed(N);
        check("ramp_valid_next_cycle", {mv_valid, sad_ready}, 2'b10);
        tick();
        check("ramp_valid_one_cycle", {mv_valid, busy}, 2'b00);

        // Tie: earliest candidate wins
        fill(32'd500);
        expect_mv(-8, -8, 32'd500);
        start_pulse();
        feed(N);
        tick();

        // Centre minimum
        fill(32'd100);
        sads[144] = 32'd3;
        expect_mv(0, 0, 32'd3);
        start_pulse();
        feed(N);
        tick();

        // Backpressure with an ignored start; k=200 -> dx=+5, dy=+3
        fill(32'd200);
        sads[200] = 32'd9;
        expect_mv(5, 3, 32'd9);
        mv_ready = 1'b0;
        start_pulse();
        feed(N);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_flags", {mv_valid, sad_ready}, 2'b10);
            check("bp_hold_outputs", {mv_x, mv_y, min_sad}, {5'sd5, 5'sd3, 32'd9});
            if (i == 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("bp_still_done", {mv_valid, cand_cnt}, {1'b1, 9'd289});
        mv_ready = 1'b1;
        tick();
        check("bp_release_idle", {mv_valid, busy}, 2'b00);

        // Restart mid-scan: SAD presented with start is dropped
        fill(32'd1);
        start_pulse();
        feed(100);
        start = 1'b1; sad_valid = 1'b1; sad_in = 32'd1;
        tick();
        start = 1'b0; sad_valid = 1'b0;
        check("restart_cleared", {busy, cand_cnt}, {1'b1, 9'd0});
        fill(32'd50);
        sads[17] = 32'd7;
        expect_mv(-8, -7, 32'd7);
        feed(N);
        tick();

        // Zero-vector bias
        fill(32'd1000);
        sads[0]   = 32'd120;
        sads[144] = 32'd150;
`ifdef SAD_ZMV_BIAS_EN
        expect_mv(0, 0, 32'd150);
`else
        expect_mv(-8, -8, 32'd120);
`endif
        start_pulse();
        feed(N);
        tick();

        // Asynchronous reset mid-scan
        fill(32'd60);
        start_pulse();
        feed(50);
        check("midscan_cnt", {busy, cand_cnt}, {1'b1, 9'd50});
        #2 rst = 1'b0;
        #1;
        check("async_reset_flags", {mv_valid, sad_ready, busy}, 3'b000);
        check("async_reset_outputs", {mv_x, mv_y, min_sad, cand_cnt}, '0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Post-reset search; k=50 -> dx=+8, dy=-6
        sads[50] = 32'd5;
        expect_mv(8, -6, 32'd5);
        start_pulse();
        feed(N);
        tick();
        repeat (2) tick();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
